// File: rtl/vpu_src_fetch_unit_pkg.sv
// Shared VPU constants for the source-operand read path, plus the read-address
// split helpers that mirror the write-side bank/row helpers.
package vpu_src_fetch_unit_pkg;

  localparam int DWIDTH_PER_EXEC     = 32;
  localparam int EXEC_CNT            = 4;
  localparam int EXEC_CNT_LG2        = $clog2(EXEC_CNT);
  localparam int SRAM_BANK_CNT_LG2   = 3;
  localparam int SRAM_BANK_DEPTH_LG2 = 8;
  localparam int SRAM_DATA_WIDTH     = EXEC_CNT * DWIDTH_PER_EXEC;
  localparam int SRAM_ADDR_WIDTH     = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
  localparam int SRC_OPND_MAX        = 3;

  // Line addresses carry the bank id in the MSBs and the row in the LSBs.
  function automatic logic [SRAM_BANK_CNT_LG2-1:0] get_rbank_id(
    input logic [SRAM_ADDR_WIDTH-1:0] addr
  );
    return addr[SRAM_ADDR_WIDTH-1 -: SRAM_BANK_CNT_LG2];
  endfunction

  function automatic logic [SRAM_BANK_DEPTH_LG2-1:0] get_raddr(
    input logic [SRAM_ADDR_WIDTH-1:0] addr
  );
    return addr[SRAM_BANK_DEPTH_LG2-1:0];
  endfunction

endpackage

// File: rtl/vpu_src_line_buf.sv
// Holds up to three fetched SRAM lines and presents the beat-indexed slice of
// each one to the lane; operands beyond the active count read as zero.
module vpu_src_line_buf #(
  parameter int DWIDTH_PER_EXEC = vpu_src_fetch_unit_pkg::DWIDTH_PER_EXEC,
  parameter int EXEC_CNT        = vpu_src_fetch_unit_pkg::EXEC_CNT,
  parameter int SRAM_DATA_WIDTH = EXEC_CNT * DWIDTH_PER_EXEC,
  parameter int BEAT_W          = $clog2(EXEC_CNT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_idx,
  input  logic [SRAM_DATA_WIDTH-1:0] wr_data,
  input  logic [1:0]                 cnt,
  input  logic [BEAT_W-1:0]          beat,
  output logic [DWIDTH_PER_EXEC-1:0] op0,
  output logic [DWIDTH_PER_EXEC-1:0] op1,
  output logic [DWIDTH_PER_EXEC-1:0] op2
);
  import vpu_src_fetch_unit_pkg::*;

  logic [SRAM_DATA_WIDTH-1:0] line  [SRC_OPND_MAX];
  logic [DWIDTH_PER_EXEC-1:0] slice [SRC_OPND_MAX];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SRC_OPND_MAX; k++) line[k] <= '0;
    end else begin
      for (int k = 0; k < SRC_OPND_MAX; k++) begin
        if (wr_en && (wr_idx == 2'(k))) line[k] <= wr_data;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < SRC_OPND_MAX; k++) begin
      slice[k] = '0;
      if (k < int'(cnt)) slice[k] = line[k][int'(beat)*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC];
    end
  end

  assign op0 = slice[0];
  assign op1 = slice[1];
  assign op2 = slice[2];

endmodule

// File: rtl/vpu_src_fetch_unit.sv
// Fetches 1-3 operand lines from SRAM, one request at a time, then streams
// them to the VPU lane as EXEC_CNT aligned beats.
module vpu_src_fetch_unit #(
  parameter int DWIDTH_PER_EXEC     = vpu_src_fetch_unit_pkg::DWIDTH_PER_EXEC,
  parameter int EXEC_CNT            = vpu_src_fetch_unit_pkg::EXEC_CNT,
  parameter int SRAM_BANK_CNT_LG2   = vpu_src_fetch_unit_pkg::SRAM_BANK_CNT_LG2,
  parameter int SRAM_BANK_DEPTH_LG2 = vpu_src_fetch_unit_pkg::SRAM_BANK_DEPTH_LG2,
  parameter int SRAM_DATA_WIDTH     = EXEC_CNT * DWIDTH_PER_EXEC
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start_i,
  output logic                                         done_o,
  input  logic [1:0]                                   src_cnt_i,
  input  logic [SRAM_BANK_CNT_LG2+SRAM_BANK_DEPTH_LG2-1:0] raddr0_i,
  input  logic [SRAM_BANK_CNT_LG2+SRAM_BANK_DEPTH_LG2-1:0] raddr1_i,
  input  logic [SRAM_BANK_CNT_LG2+SRAM_BANK_DEPTH_LG2-1:0] raddr2_i,
  output logic                                         rd_req_o,
  output logic [SRAM_BANK_CNT_LG2-1:0]                 rd_rid_o,
  output logic [SRAM_BANK_DEPTH_LG2-1:0]               rd_addr_o,
  output logic                                         rd_reb_o,
  output logic                                         rd_rlast_o,
  input  logic                                         rd_ack_i,
  input  logic                                         rd_rvalid_i,
  input  logic [SRAM_DATA_WIDTH-1:0]                   rd_rdata_i,
  output logic                                         op_valid_o,
  input  logic                                         op_ready_i,
  output logic [DWIDTH_PER_EXEC-1:0]                   op0_o,
  output logic [DWIDTH_PER_EXEC-1:0]                   op1_o,
  output logic [DWIDTH_PER_EXEC-1:0]                   op2_o,
  output logic                                         op_last_o
);
  import vpu_src_fetch_unit_pkg::*;

  localparam int ADDR_W = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
  localparam int BEAT_W = $clog2(EXEC_CNT);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(EXEC_CNT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_t;

  state_t state, next_state;
  logic [1:0] cnt, next_cnt, idx, next_idx;
  logic [BEAT_W-1:0] beat, next_beat;
  logic [ADDR_W-1:0] addr0, addr1, addr2, req_addr;
  logic req_d, reb_d, rlast_d, valid_d, last_d;
  logic [SRAM_BANK_CNT_LG2-1:0] rid_d;
  logic [SRAM_BANK_DEPTH_LG2-1:0] row_d;
  logic req_fire, beat_fire, last_opnd, wr_en;

  assign req_fire  = rd_req_o && rd_ack_i;
  assign beat_fire = op_valid_o && op_ready_i;
  assign last_opnd = (idx == cnt - 2'd1);
  assign wr_en     = (state == WAIT) && rd_rvalid_i;
  assign done_o    = (state == IDLE);

  // Outputs are registered from the next-state decode, so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd1;
      idx        <= '0;
      beat       <= '0;
      rd_req_o   <= 1'b0;
      rd_reb_o   <= 1'b1;
      rd_rid_o   <= '0;
      rd_addr_o  <= '0;
      rd_rlast_o <= 1'b0;
      op_valid_o <= 1'b0;
      op_last_o  <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      idx        <= next_idx;
      beat       <= next_beat;
      rd_req_o   <= req_d;
      rd_reb_o   <= reb_d;
      rd_rid_o   <= rid_d;
      rd_addr_o  <= row_d;
      rd_rlast_o <= rlast_d;
      op_valid_o <= valid_d;
      op_last_o  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr0 <= '0;
      addr1 <= '0;
      addr2 <= '0;
    end else if ((state == IDLE) && start_i) begin
      addr0 <= raddr0_i;
      addr1 <= raddr1_i;
      addr2 <= raddr2_i;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_idx   = idx;
    next_beat  = beat;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          next_state = REQ;
          next_cnt   = (src_cnt_i == 2'd0) ? 2'd1 : src_cnt_i;
          next_idx   = '0;
        end
      end
      REQ: begin
        if (req_fire) next_state = WAIT;
      end
      WAIT: begin
        if (rd_rvalid_i) begin
          if (last_opnd) begin
            next_state = STREAM;
            next_beat  = '0;
          end else begin
            next_state = REQ;
            next_idx   = idx + 2'd1;
          end
        end
      end
      STREAM: begin
        if (beat_fire) begin
          if (beat == LAST_BEAT) next_state = IDLE;
          else                   next_beat  = beat + BEAT_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The first request is issued straight from the ports because the address registers load on the same edge.
  always_comb begin
    unique case (next_idx)
      2'd1:    req_addr = addr1;
      2'd2:    req_addr = addr2;
      default: req_addr = addr0;
    endcase
    if (state == IDLE) req_addr = raddr0_i;
    req_d   = (next_state == REQ);
    reb_d   = !req_d;
    rid_d   = req_d ? get_rbank_id(req_addr) : '0;
    row_d   = req_d ? get_raddr(req_addr) : '0;
    rlast_d = req_d && (next_idx == next_cnt - 2'd1);
    valid_d = (next_state == STREAM);
    last_d  = valid_d && (next_beat == LAST_BEAT);
  end

  vpu_src_line_buf #(
    .DWIDTH_PER_EXEC (DWIDTH_PER_EXEC),
    .EXEC_CNT        (EXEC_CNT),
    .SRAM_DATA_WIDTH (SRAM_DATA_WIDTH),
    .BEAT_W          (BEAT_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (rd_rdata_i),
    .cnt     (cnt),
    .beat    (beat),
    .op0     (op0_o),
    .op1     (op1_o),
    .op2     (op2_o)
  );

endmodule

// File: tb/tb_vpu_src_fetch_unit.sv
// Self-checking bench: an SRAM responder feeds lines from a small memory and a
// transaction-level model predicts every request and every lane beat.
module tb_vpu_src_fetch_unit;
  import vpu_src_fetch_unit_pkg::*;

  localparam int DW = 32;
  localparam int EC = 4;
  localparam int BK = 3;
  localparam int RW = 8;
  localparam int AW = BK + RW;
  localparam int LW = EC * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic done_o;
  logic [1:0] src_cnt_i = 2'd1;
  logic [AW-1:0] raddr0_i = '0, raddr1_i = '0, raddr2_i = '0;
  logic rd_req_o, rd_reb_o, rd_rlast_o;
  logic [BK-1:0] rd_rid_o;
  logic [RW-1:0] rd_addr_o;
  logic rd_ack_i = 1'b0;
  logic rd_rvalid_i = 1'b0;
  logic [LW-1:0] rd_rdata_i = '0;
  logic op_valid_o, op_last_o;
  logic op_ready_i = 1'b1;
  logic [DW-1:0] op0_o, op1_o, op2_o;

  always #5 clk = ~clk;

  vpu_src_fetch_unit #(
    .DWIDTH_PER_EXEC (DW),
    .EXEC_CNT        (EC),
    .SRAM_BANK_CNT_LG2   (BK),
    .SRAM_BANK_DEPTH_LG2 (RW),
    .SRAM_DATA_WIDTH     (LW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start_i (start_i), .done_o (done_o),
    .src_cnt_i (src_cnt_i), .raddr0_i (raddr0_i), .raddr1_i (raddr1_i), .raddr2_i (raddr2_i),
    .rd_req_o (rd_req_o), .rd_rid_o (rd_rid_o), .rd_addr_o (rd_addr_o), .rd_reb_o (rd_reb_o),
    .rd_rlast_o (rd_rlast_o), .rd_ack_i (rd_ack_i), .rd_rvalid_i (rd_rvalid_i), .rd_rdata_i (rd_rdata_i),
    .op_valid_o (op_valid_o), .op_ready_i (op_ready_i), .op0_o (op0_o), .op1_o (op1_o), .op2_o (op2_o),
    .op_last_o (op_last_o)
  );

  typedef struct packed {
    logic [BK-1:0] rid;
    logic [RW-1:0] row;
    logic          rlast;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] o0;
    logic [DW-1:0] o1;
    logic [DW-1:0] o2;
    logic          last;
  } beat_t;

  req_t  exp_req[$];
  beat_t exp_beat[$];
  logic [LW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] lit_op [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  int passed = 0;
  int total = 0;
  bit cmp_en = 1'b0;

  int ack_delay = 0, rv_lat = 1, ack_wait = 0, rv_wait = 0;
  bit rv_pend = 1'b0, spurious = 1'b0, spur_req_done = 1'b0, spur_strm_done = 1'b0;
  logic [AW-1:0] rv_addr = '0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // SRAM responder: acks after ack_delay cycles, returns data rv_lat cycles later.
  initial forever begin
    @(negedge clk);
    rd_ack_i = 1'b0;
    rd_rvalid_i = 1'b0;
    rd_rdata_i = '0;
    if (!rst_n) begin
      rv_pend = 1'b0;
      ack_wait = ack_delay;
    end else if (rv_pend) begin
      if (rv_wait == 0) begin
        rd_rvalid_i = 1'b1;
        rd_rdata_i = mem[rv_addr];
        rv_pend = 1'b0;
      end else rv_wait--;
    end else if (rd_req_o === 1'b1) begin
      if (ack_wait == 0) begin
        rd_ack_i = 1'b1;
        rv_addr = {rd_rid_o, rd_addr_o};
        rv_pend = 1'b1;
        rv_wait = rv_lat - 1;
        ack_wait = ack_delay;
        spur_req_done = 1'b0;
      end else begin
        ack_wait--;
        if (spurious && !spur_req_done) begin
          rd_rvalid_i = 1'b1;
          rd_rdata_i = {4{32'hDEADBEEF}};
          spur_req_done = 1'b1;
        end
      end
    end else if (spurious && !spur_strm_done && op_valid_o === 1'b1) begin
      rd_rvalid_i = 1'b1;
      rd_rdata_i = {4{32'hDEADBEEF}};
      spur_strm_done = 1'b1;
    end
  end

  // Compare process: every cycle, requests and beats against the model queues.
  initial forever begin
    @(negedge clk);
    #1;
    if (cmp_en) begin
      if (rd_req_o) begin
        if (exp_req.size() == 0) checkOutput("req_unexpected", 1, 0);
        else begin
          checkOutput("rd_rid", rd_rid_o, exp_req[0].rid);
          checkOutput("rd_addr", rd_addr_o, exp_req[0].row);
          checkOutput("rd_rlast", rd_rlast_o, exp_req[0].rlast);
          checkOutput("rd_reb", rd_reb_o, 0);
          if (rd_ack_i) void'(exp_req.pop_front());
        end
      end else begin
        checkOutput("req_idle_fields", {rd_reb_o, rd_rid_o, rd_addr_o, rd_rlast_o}, 13'h1000);
      end
      if (op_valid_o) begin
        if (exp_beat.size() == 0) checkOutput("beat_unexpected", 1, 0);
        else begin
          checkOutput("op0", op0_o, exp_beat[0].o0);
          checkOutput("op1", op1_o, exp_beat[0].o1);
          checkOutput("op2", op2_o, exp_beat[0].o2);
          checkOutput("op_last", op_last_o, exp_beat[0].last);
          if (op_ready_i) void'(exp_beat.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    cmp_en = 1'b0;
    rst_n = 1'b0;
    start_i = 1'b0;
    op_ready_i = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_done", done_o, 1);
    checkOutput("rst_req_fields", {rd_req_o, rd_rid_o, rd_addr_o, rd_reb_o, rd_rlast_o}, 14'h0002);
    checkOutput("rst_valid_last", {op_valid_o, op_last_o}, 0);
    checkOutput("rst_ops", {op0_o, op1_o, op2_o}, 0);
    exp_req.delete();
    exp_beat.delete();
    rst_n = 1'b1;
    cmp_en = 1'b1;
  endtask

  task automatic applyStimulus(input logic [1:0] cnt_raw, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input int ack_d, input int rv_l, input int bp_beat,
                               input int bp_cyc, input bit mid_start, input bit spur, input int abort_at,
                               input bit lit);
    logic [AW-1:0] a [3];
    beat_t e;
    int n, cyc, first_valid, bp_left, bi;
    bit seen_req;
    a[0] = a0; a[1] = a1; a[2] = a2;
    n = (cnt_raw == 2'd0) ? 1 : int'(cnt_raw);
    ack_delay = ack_d; ack_wait = ack_d; rv_lat = rv_l;
    spurious = spur; spur_req_done = 1'b0; spur_strm_done = 1'b0;
    for (int k = 0; k < n; k++) exp_req.push_back('{rid: a[k][AW-1 -: BK], row: a[k][RW-1:0], rlast: (k == n - 1)});
    for (int b = 0; b < EC; b++) begin
      e = '0;
      e.o0 = DW'(mem[a[0]] >> (DW * b));
      if (n > 1) e.o1 = DW'(mem[a[1]] >> (DW * b));
      if (n > 2) e.o2 = DW'(mem[a[2]] >> (DW * b));
      e.last = (b == EC - 1);
      exp_beat.push_back(e);
    end
    checkOutput("done_before_start", done_o, 1);
    start_i = 1'b1; src_cnt_i = cnt_raw;
    raddr0_i = a0; raddr1_i = a1; raddr2_i = a2;
    @(negedge clk);
    start_i = 1'b0; src_cnt_i = cnt_raw ^ 2'b11;
    raddr0_i = ~a0; raddr1_i = ~a1; raddr2_i = ~a2;
    cyc = 1; first_valid = -1; bp_left = bp_cyc; seen_req = 1'b0;
    while (!done_o) begin
      if (abort_at > 0 && cyc == abort_at) begin
        do_reset();
        return;
      end
      if (cyc > 400) begin
        checkOutput("run_timeout", 1, 0);
        do_reset();
        return;
      end
      if (op_valid_o && first_valid < 0) first_valid = cyc;
      bi = EC - exp_beat.size();
      op_ready_i = !(op_valid_o && bi == bp_beat && bp_left > 0);
      if (!op_ready_i) bp_left--;
      start_i = mid_start && op_valid_o && (bi == 2);
      if (lit && rd_req_o && !seen_req) begin
        seen_req = 1'b1;
        checkOutput("t1_rid", rd_rid_o, 2);
        checkOutput("t1_addr", rd_addr_o, 8'h15);
        checkOutput("t1_reb", rd_reb_o, 0);
        checkOutput("t1_rlast", rd_rlast_o, 1);
      end
      if (lit && op_valid_o && op_ready_i && bi < EC) begin
        checkOutput("t1_op0", op0_o, lit_op[bi]);
        checkOutput("t1_op12", {op1_o, op2_o}, 0);
        checkOutput("t1_last", op_last_o, (bi == 3) ? 1 : 0);
      end
      @(negedge clk);
      cyc++;
    end
    op_ready_i = 1'b1;
    start_i = 1'b0;
    checkOutput("queues_drained", {exp_req.size(), exp_beat.size()}, 0);
    if (lit) checkOutput("t1_valid_cycle", first_valid, 3);
    if (ack_d == 0 && rv_l == 1 && bp_cyc == 0) begin
      checkOutput("first_valid_latency", first_valid, 1 + 2 * n);
      checkOutput("done_latency", cyc, 1 + 2 * n + EC);
    end
  endtask

  initial begin
    mem[{3'd2, 8'h15}] = 128'h44444444_33333333_22222222_11111111;
    mem[{3'd1, 8'h20}] = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    mem[{3'd5, 8'h7F}] = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    mem[{3'd7, 8'hFF}] = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    mem[{3'd0, 8'h01}] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    mem[{3'd6, 8'h42}] = 128'h89ABCDEF_01234567_FEDCBA98_76543210;
    @(negedge clk);
    do_reset();
    $display("[TB] single operand, minimum latency");
    applyStimulus(2'd1, {3'd2, 8'h15}, {3'd1, 8'h20}, {3'd5, 8'h7F}, 0, 1, -1, 0, 1'b0, 1'b0, 0, 1'b1);
    $display("[TB] three operands, ack delayed 3, back-to-back start");
    applyStimulus(2'd3, {3'd1, 8'h20}, {3'd5, 8'h7F}, {3'd7, 8'hFF}, 3, 1, -1, 0, 1'b0, 1'b0, 0, 1'b0);
    $display("[TB] two operands, backpressure on beat 1, start mid-stream");
    applyStimulus(2'd2, {3'd0, 8'h01}, {3'd6, 8'h42}, {3'd2, 8'h15}, 0, 2, 1, 2, 1'b1, 1'b0, 0, 1'b0);
    $display("[TB] three operands, minimum latency");
    applyStimulus(2'd3, {3'd6, 8'h42}, {3'd2, 8'h15}, {3'd0, 8'h01}, 0, 1, -1, 0, 1'b0, 1'b0, 0, 1'b0);
    $display("[TB] spurious rvalid in REQ and STREAM");
    applyStimulus(2'd3, {3'd7, 8'hFF}, {3'd0, 8'h01}, {3'd1, 8'h20}, 2, 1, -1, 0, 1'b0, 1'b1, 0, 1'b0);
    $display("[TB] reset during WAIT");
    applyStimulus(2'd2, {3'd5, 8'h7F}, {3'd6, 8'h42}, {3'd0, 8'h01}, 0, 6, -1, 0, 1'b0, 1'b0, 4, 1'b0);
    applyStimulus(2'd2, {3'd5, 8'h7F}, {3'd6, 8'h42}, {3'd0, 8'h01}, 1, 2, 3, 1, 1'b0, 1'b0, 0, 1'b0);
    $display("[TB] src_cnt 0 behaves as 1");
    applyStimulus(2'd0, {3'd6, 8'h42}, {3'd1, 8'h20}, {3'd7, 8'hFF}, 0, 1, -1, 0, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("final_done", done_o, 1);
    checkOutput("final_no_req", rd_req_o, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
